dot_sched: RTL and testbench
============================

# dot_sched

Sequencer for the 8-lane signed MAC datapath (`baseline`). It accepts a dot-product job of 1..MAX_CHUNKS chunks of 8 operand pairs. It streams the chunks into the MAC through a valid/ready handshake and tracks in-flight chunks across the fixed MAC pipeline latency. It accumulates both MAC partial sums into one running total and returns a single scalar result through a second handshake. It sits between the operand fetch logic and the MAC instance.

## Interface
- IN_SIZE_0, 4, signed width of lane operand 0
- IN_SIZE_1, 8, signed width of lane operand 1
- MAC_LAT, 3, MAC latency in cycles, from inputs applied to partial sums valid
- MAX_CHUNKS, 16, maximum job length in chunks, power of two
- RES_SIZE, 16, signed width of the returned result
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- cfg_valid_i  in  1  job request
- cfg_len_i  in  $clog2(MAX_CHUNKS)+1  job length in chunks, 0..MAX_CHUNKS
- cfg_ready_o  out  1  job accepted when high together with cfg_valid_i
- data_valid_i  in  1  chunk beat valid
- data_in_0_i  in  8×IN_SIZE_0  lane operands 0, packed
- data_in_1_i  in  8×IN_SIZE_1  lane operands 1, packed
- data_ready_o  out  1  chunk beat accepted
- mac_in_0_o  out  8×IN_SIZE_0  to MAC in_0_i
- mac_in_1_o  out  8×IN_SIZE_1  to MAC in_1_i
- mac_out_i  in  2×OUT_SIZE  MAC partial sums; OUT_SIZE = IN_SIZE_0+IN_SIZE_1+8
- res_valid_o  out  1  result valid
- res_data_o  out  RES_SIZE  signed dot product
- res_ready_i  in  1  result consumed
- busy_o  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: cfg_ready_o=1. On a cfg handshake the block latches len, clears acc, issued_cnt and retired_cnt, and goes to STREAM. With len=0 it goes directly to DONE and the result is 0.
- STREAM: data_ready_o=1 while issued_cnt<len. Each beat handshake registers the operands into mac_in_*_o, increments issued_cnt and sets vpipe[0]. After the last beat the FSM goes to DRAIN. When no beat is accepted, mac_in_*_o is driven to zero.
- vpipe is a valid shift register with MAC_LAT+1 stages. When vpipe[MAC_LAT]=1: acc += signed(mac_out_i[0]) + signed(mac_out_i[1]) and retired_cnt is incremented.
- DRAIN: no beats are accepted. When retired_cnt reaches len, the FSM goes to DONE.
- DONE: res_valid_o=1 and res_data_o is held stable until res_ready_i. The handshake returns the FSM to IDLE. cfg_ready_o=0 in this state.
- ACC_SIZE = OUT_SIZE+$clog2(MAX_CHUNKS). The accumulator never overflows internally.
- Out-of-range cfg_len_i (>MAX_CHUNKS) is clamped to MAX_CHUNKS.

## Timing
- Reset values: cfg_ready_o=1 (IDLE after reset), data_ready_o=0, res_valid_o=0, res_data_o=0, mac_in_*_o=0, busy_o=0. acc, counters and vpipe are cleared.
- Accepted beats are registered into mac_in_*_o one cycle after the handshake.
- A chunk accepted in cycle c is accumulated at the end of cycle c+1+MAC_LAT.
- res_valid_o rises MAC_LAT+2 cycles after the last beat handshake.
- Back-to-back beats are sustained at 1 per cycle.
- cfg_ready_o is high in the first cycle after the result handshake.
- Reset mid-job discards all in-flight chunks. Stale mac_out_i values are ignored because vpipe is cleared.
- data_valid_i outside STREAM is ignored. cfg_valid_i outside IDLE is ignored.

## Configuration
- DOT_SAT_EN defined: res_data_o is acc saturated to the signed RES_SIZE range, [-2^(RES_SIZE-1), 2^(RES_SIZE-1)-1].
- DOT_SAT_EN undefined: res_data_o = acc[RES_SIZE-1:0] (two's-complement wrap).

## Structure
- Package dot_sched_pkg holds:
  - the FSM state enum
  - the OUT_SIZE and ACC_SIZE helper functions
  - the default MAC_LAT constant
- Sub-module dot_sched_sat: a combinational ACC_SIZE→RES_SIZE narrowing unit, with saturation or wrap selected by DOT_SAT_EN.
- The MAC is instantiated beside this block, not inside it.

## Test plan
All cases use default parameters and a reference MAC model with latency 3.
- Single chunk: len=1, all lanes 1×1 → res_data_o=8, res_valid_o exactly 5 cycles after the beat handshake.
- Max positive: len=4, all lanes 7×127 → 28448 (sat on: 28448, sat off: 28448).
- Min negative: len=16, all lanes -8×-128 → acc=131072. With DOT_SAT_EN res_data_o=32767; without it res_data_o=0.
- Empty job and back-pressure: len=0 → res_valid_o with res_data_o=0. Then hold res_ready_i=0 for 10 cycles → result stable and cfg_ready_o=0.
- Bubbles: len=3 with random values and data_valid_i gaps of 0..4 cycles between beats → result equals the model sum, and mac_in_*_o=0 during gaps.
- Reset mid-job: rst_i high for 1 cycle during DRAIN of a len=8 job, then a new len=1 job of 1×1 → result 8, with no contamination from the aborted job.

Source files
------------

// File: rtl/dot_sched_pkg.sv
// dot_sched_pkg: shared FSM state type, width helpers and default
// MAC latency for the dot_sched sequencer and its narrowing unit.
package dot_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } dot_state_e;

    localparam int DEF_MAC_LAT = 3;

    // Width of one MAC partial sum: a signed product plus 3 bits of
    // growth for summing lanes, with headroom the MAC reserves.
    function automatic int out_size(input int in0, input int in1);
        return in0 + in1 + 8;
    endfunction

    // Accumulator width: one partial-sum width plus log2 of the job
    // length, so the running total never overflows.
    function automatic int acc_size(
        input int in0,
        input int in1,
        input int max_chunks
    );
        return out_size(in0, in1) + $clog2(max_chunks);
    endfunction

endpackage

// File: rtl/dot_sched_sat.sv
// dot_sched_sat: combinational narrowing of the wide accumulator to the
// result width. Build macro DOT_SAT_EN selects saturation; without it the
// result is the two's-complement wrap (low RES_W bits).
// Ports:
//   acc_i  in   ACC_W  signed accumulator value
//   res_o  out  RES_W  signed narrowed result
module dot_sched_sat #(
    parameter int ACC_W = 24,
    parameter int RES_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [RES_W-1:0] res_o
);

`ifdef DOT_SAT_EN
    localparam logic signed [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic signed [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};

    always_comb begin
        res_o = RES_W'(acc_i);
        if (acc_i > ACC_W'(RES_MAX)) begin
            res_o = RES_MAX;
        end else if (acc_i < ACC_W'(RES_MIN)) begin
            res_o = RES_MIN;
        end
    end
`else
    assign res_o = RES_W'(acc_i);
`endif

endmodule

// File: rtl/dot_sched.sv
// dot_sched: sequences a dot-product job of 0..MAX_CHUNKS chunks through an
// external 8-lane MAC, accumulates both partial sums and returns one scalar.
// Build macro DOT_SAT_EN: saturate the result instead of wrapping it.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cfg_valid_i/cfg_len_i/cfg_ready_o   job request handshake
//   data_valid_i/data_in_*_i/data_ready_o  chunk beat handshake
//   mac_in_0_o, mac_in_1_o         registered operands to the MAC
//   mac_out_i                      MAC partial sums {psum1, psum0}
//   res_valid_o/res_data_o/res_ready_i  result handshake
//   busy_o                         high whenever not idle
module dot_sched
    import dot_sched_pkg::*;
#(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int MAC_LAT    = DEF_MAC_LAT,
    parameter int MAX_CHUNKS = 16,
    parameter int RES_SIZE   = 16,
    localparam int OUT_SIZE  = out_size(IN_SIZE_0, IN_SIZE_1),
    localparam int LEN_W     = $clog2(MAX_CHUNKS) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_valid_i,
    input  logic [LEN_W-1:0]             cfg_len_i,
    output logic                         cfg_ready_o,
    input  logic                         data_valid_i,
    input  logic [8*IN_SIZE_0-1:0]       data_in_0_i,
    input  logic [8*IN_SIZE_1-1:0]       data_in_1_i,
    output logic                         data_ready_o,
    output logic [8*IN_SIZE_0-1:0]       mac_in_0_o,
    output logic [8*IN_SIZE_1-1:0]       mac_in_1_o,
    input  logic [2*OUT_SIZE-1:0]        mac_out_i,
    output logic                         res_valid_o,
    output logic signed [RES_SIZE-1:0]   res_data_o,
    input  logic                         res_ready_i,
    output logic                         busy_o
);

    localparam int ACC_SIZE = acc_size(IN_SIZE_0, IN_SIZE_1, MAX_CHUNKS);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNKS);

    dot_state_e state_q, state_d;

    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           issued_q, issued_d;
    logic [LEN_W-1:0]           retired_q, retired_d;
    logic signed [ACC_SIZE-1:0] acc_q, acc_d;
    logic [MAC_LAT:0]           vpipe_q, vpipe_d;
    logic [8*IN_SIZE_0-1:0]     mac_in_0_q, mac_in_0_d;
    logic [8*IN_SIZE_1-1:0]     mac_in_1_q, mac_in_1_d;

    logic                       cfg_hs;
    logic                       beat_hs;
    logic                       retire;
    logic                       last_retire;
    logic [LEN_W-1:0]           cfg_len_clamp;
    logic signed [OUT_SIZE-1:0] psum_0;
    logic signed [OUT_SIZE-1:0] psum_1;

    assign cfg_len_clamp = (cfg_len_i > MAX_LEN) ? MAX_LEN : cfg_len_i;
    assign psum_0        = mac_out_i[OUT_SIZE-1:0];
    assign psum_1        = mac_out_i[2*OUT_SIZE-1:OUT_SIZE];

    // The last stage of the valid pipe lines up with the MAC output
    // belonging to the chunk issued MAC_LAT+1 cycles earlier.
    assign retire      = vpipe_q[MAC_LAT];
    assign last_retire = (retired_q + LEN_W'(retire)) == len_q;

    // FSM: next state and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        cfg_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        res_valid_o  = 1'b0;
        busy_o       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i) begin
                    state_d = (cfg_len_clamp == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                data_ready_o = issued_q < len_q;
                if (data_ready_o && data_valid_i &&
                    (issued_q == len_q - LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_retire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cfg_hs  = cfg_ready_o && cfg_valid_i;
    assign beat_hs = data_ready_o && data_valid_i;

    // Datapath next-state: job setup, beat issue, chunk retirement.
    always_comb begin
        len_d      = len_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        acc_d      = acc_q;
        vpipe_d    = {vpipe_q[MAC_LAT-1:0], beat_hs};
        mac_in_0_d = '0;
        mac_in_1_d = '0;
        if (cfg_hs) begin
            len_d     = cfg_len_clamp;
            issued_d  = '0;
            retired_d = '0;
            acc_d     = '0;
        end
        if (beat_hs) begin
            mac_in_0_d = data_in_0_i;
            mac_in_1_d = data_in_1_i;
            issued_d   = issued_q + LEN_W'(1);
        end
        if (retire) begin
            acc_d     = acc_q + ACC_SIZE'(psum_0) + ACC_SIZE'(psum_1);
            retired_d = retired_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            acc_q      <= '0;
            vpipe_q    <= '0;
            mac_in_0_q <= '0;
            mac_in_1_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            acc_q      <= acc_d;
            vpipe_q    <= vpipe_d;
            mac_in_0_q <= mac_in_0_d;
            mac_in_1_q <= mac_in_1_d;
        end
    end

    assign mac_in_0_o = mac_in_0_q;
    assign mac_in_1_o = mac_in_1_q;

    // acc_q is frozen in DONE, which keeps the result stable under
    // back-pressure.
    dot_sched_sat #(
        .ACC_W (ACC_SIZE),
        .RES_W (RES_SIZE)
    ) u_sat (
        .acc_i (acc_q),
        .res_o (res_data_o)
    );

endmodule

// File: tb/tb_dot_sched.sv
// tb_dot_sched: scoreboard bench for dot_sched with a latency-3 MAC model.
// Expected results are queued when a job is driven, checked on result.
module tb_dot_sched;

    localparam int IN0  = 4;
    localparam int IN1  = 8;
    localparam int LAT  = 3;
    localparam int MAXC = 16;
    localparam int RESW = 16;
    localparam int OUTW = IN0 + IN1 + 8;
    localparam int LW   = $clog2(MAXC) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_valid;
    logic [LW-1:0]       cfg_len;
    logic                cfg_ready;
    logic                data_valid;
    logic [8*IN0-1:0]    d_in0;
    logic [8*IN1-1:0]    d_in1;
    logic                data_ready;
    logic [8*IN0-1:0]    mac_in0;
    logic [8*IN1-1:0]    mac_in1;
    logic [2*OUTW-1:0]   mac_out;
    logic                res_valid;
    logic [RESW-1:0]     res_data;
    logic                res_ready;
    logic                busy;

    int checks = 0;
    int errs   = 0;

    logic [RESW-1:0]   exp_q [$];
    logic [8*IN0-1:0]  d0 [MAXC];
    logic [8*IN1-1:0]  d1 [MAXC];
    logic [2*OUTW-1:0] mpipe [LAT];

    always #5 clk = ~clk;

    dot_sched #(
        .IN_SIZE_0  (IN0),
        .IN_SIZE_1  (IN1),
        .MAC_LAT    (LAT),
        .MAX_CHUNKS (MAXC),
        .RES_SIZE   (RESW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_len_i    (cfg_len),
        .cfg_ready_o  (cfg_ready),
        .data_valid_i (data_valid),
        .data_in_0_i  (d_in0),
        .data_in_1_i  (d_in1),
        .data_ready_o (data_ready),
        .mac_in_0_o   (mac_in0),
        .mac_in_1_o   (mac_in1),
        .mac_out_i    (mac_out),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_ready_i  (res_ready),
        .busy_o       (busy)
    );

    // Reference MAC: lanes 0..3 into psum0, lanes 4..7 into psum1.
    function automatic logic [2*OUTW-1:0] mac_f(
        input logic [8*IN0-1:0] a,
        input logic [8*IN1-1:0] b
    );
        int s0;
        int s1;
        int p;
        s0 = 0;
        s1 = 0;
        for (int l = 0; l < 8; l++) begin
            p = int'($signed(a[l*IN0 +: IN0])) * int'($signed(b[l*IN1 +: IN1]));
            if (l < 4) s0 += p;
            else s1 += p;
        end
        return {OUTW'(s1), OUTW'(s0)};
    endfunction

    initial begin
        for (int i = 0; i < LAT; i++) mpipe[i] = '0;
    end

    always @(posedge clk) begin
        mpipe[0] <= mac_f(mac_in0, mac_in1);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end

    assign mac_out = mpipe[LAT-1];

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int n, input bit rnd, input int a, input int b);
        for (int c = 0; c < n; c++) begin
            for (int l = 0; l < 8; l++) begin
                d0[c][l*IN0 +: IN0] = rnd ? IN0'($urandom) : IN0'(a);
                d1[c][l*IN1 +: IN1] = rnd ? IN1'($urandom) : IN1'(b);
            end
        end
    endtask

    function automatic logic [RESW-1:0] exp_of(input int n);
        longint s;
        s = 0;
        for (int c = 0; c < n; c++) begin
            for (int l = 0; l < 8; l++) begin
                s += longint'($signed(d0[c][l*IN0 +: IN0])) *
                     longint'($signed(d1[c][l*IN1 +: IN1]));
            end
        end
`ifdef DOT_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return RESW'(s);
    endfunction

    task automatic check_reset_state(input string pfx);
        check({pfx, "_cfgrdy"}, cfg_ready, 1);
        check({pfx, "_datrdy"}, data_ready, 0);
        check({pfx, "_resvld"}, res_valid, 0);
        check({pfx, "_resdat"}, res_data, 0);
        check({pfx, "_macin0"}, mac_in0, 0);
        check({pfx, "_macin1"}, mac_in1, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    task automatic run_job(
        input int cfg_l,
        input int maxgap,
        input int hold,
        input bit abort
    );
        int n;
        int gap;
        int lat;
        logic [RESW-1:0] e;
        n = (cfg_l > MAXC) ? MAXC : cfg_l;
        check("cfg_rdy", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_len   = LW'(cfg_l);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (!abort) exp_q.push_back(exp_of(n));
        for (int c = 0; c < n; c++) begin
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            for (int g = 0; g < gap; g++) begin
                data_valid = 1'b0;
                @(posedge clk); #1;
                check("gap_in0", mac_in0, 0);
                check("gap_in1", mac_in1, 0);
            end
            data_valid = 1'b1;
            d_in0 = d0[c];
            d_in1 = d1[c];
            check("dat_rdy", data_ready, 1);
            @(posedge clk); #1;
            data_valid = 1'b0;
            check("mac_in0", mac_in0, d0[c]);
            check("mac_in1", mac_in1, d1[c]);
        end
        if (abort) begin
            check("abort_busy", busy, 1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_state("abort");
            return;
        end
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        if (!res_valid) begin
            check("res_timeout", 0, 1);
            return;
        end
        if (n > 0) check("res_lat", lat, LAT + 2);
        check("res", res_data, e);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check("hold_res", res_data, e);
            check("hold_vld", res_valid, 1);
            check("hold_cfgrdy", cfg_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_cfgrdy", cfg_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_len    = '0;
        data_valid = 1'b0;
        d_in0      = '0;
        d_in1      = '0;
        res_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("rst");

        // Beats are ignored while idle.
        data_valid = 1'b1;
        d_in0      = '1;
        d_in1      = '1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        check("idle_in0", mac_in0, 0);
        check("idle_busy", busy, 0);

        fill(1, 1'b0, 1, 1);
        run_job(1, 0, 0, 1'b0);

        fill(4, 1'b0, 7, 127);
        run_job(4, 0, 0, 1'b0);

        fill(16, 1'b0, -8, -128);
        run_job(16, 0, 0, 1'b0);

        run_job(0, 0, 10, 1'b0);

        for (int k = 0; k < 4; k++) begin
            fill(3, 1'b1, 0, 0);
            run_job(3, 4, 0, 1'b0);
        end

        fill(8, 1'b0, 3, 5);
        run_job(8, 0, 0, 1'b1);

        fill(1, 1'b0, 1, 1);
        run_job(1, 0, 0, 1'b0);

        fill(16, 1'b1, 0, 0);
        run_job(31, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
